instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 150 +++++++++++++++
 tb/tb_instr_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes a stream of RV32I instruction requests into 32-bit words and writes
// them through a small FIFO to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  input  logic        last,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] count,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and req_ready may rise combinationally when
  // a write in the same cycle frees a full FIFO entry.

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];
  localparam logic [AW:0] OCC_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [31:0]   addr;
  logic [31:0]   enc_word;
  logic          enc_reject;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

  always_comb begin
    enc_word   = '0;
    enc_reject = 1'b0;
    case (kind)
      3'd0: begin
        enc_word   = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        enc_reject = imm[12] != imm[11];
      end
      3'd1: begin
        enc_word   = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        enc_reject = imm[12] != imm[11];
      end
      3'd2: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd3: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd4: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      3'd5: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      3'd6: enc_word = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
      default: begin
        // Branch offsets are halfword-aligned, so an odd offset cannot be encoded.
        enc_word   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        enc_reject = imm[0];
      end
    endcase
  end

  assign full      = occ == FULL_OCC;
  assign wr_valid  = occ != '0;
  assign pop       = wr_valid && wr_ready;
  assign req_ready = (state == RUN) && (!full || pop);
  assign accept    = req_valid && req_ready;
  assign push      = accept && !enc_reject;
  assign wr_data   = wr_valid ? mem[rd_ptr] : '0;
  assign wr_addr   = addr;
  assign busy      = state != IDLE;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      addr   <= '0;
      count  <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            addr   <= {base_addr[31:2], 2'b00};
            count  <= '0;
            err    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
          end
        end
        RUN: begin
          if (accept && last) state <= DRAIN;
        end
        DRAIN: begin
          // Leaving only once the FIFO is empty keeps done a cycle after the last write.
          if (occ == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        addr   <= addr + 32'd4;
        count  <= count + 16'd1;
      end
      if (accept && enc_reject) err <= 1'b1;

      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table of encodings plus hand-written
// sequences for backpressure, rejected requests and mid-program reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [12:0] imm;
  logic        last;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;
  logic [1:0]  fsm_state;

  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .kind(kind), .rd(rd),
    .rs1(rs1), .rs2(rs2), .imm(imm), .last(last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .err(err), .count(count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  int rdy_mode = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic [31:0] word;
    logic        rej;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // wr_ready driver: 0 = stall, 1 = always ready, 2 = random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       wr_ready = 1'b0;
        1:       wr_ready = 1'b1;
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard compare on each write, stability while stalled
  logic        hold;
  logic [31:0] hold_d, hold_a;
  logic [63:0] e;
  initial hold = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", wr_valid, 1);
        check("stall_word", {wr_addr, wr_data}, {hold_a, hold_d});
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got %0h/%0h expected none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_word", {wr_addr, wr_data}, e);
        end
      end
      if (done) check("done_no_write", wr_valid, 0);
      hold   = wr_valid && !wr_ready;
      hold_d = wr_data;
      hold_a = wr_addr;
    end
  end

  task automatic do_start(input logic [31:0] base);
    start     = 1'b1;
    base_addr = base;
    exp_addr  = {base[31:2], 2'b00};
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [12:0] im, input logic lst,
                      input logic [31:0] word, input logic rej);
    bit ok;
    ok = 0;
    req_valid = 1'b1; kind = k; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    check("req_accept", ok, 1);
    if (ok && !rej) begin
      exp_q.push_back({exp_addr, word});
      exp_addr += 32'd4;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] exp_count, input logic exp_err);
    bit found;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    check("done_seen", found, 1);
    check("done_count", count, exp_count);
    check("done_err", err, exp_err);
    check("done_busy", busy, 0);
    check("done_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] addi_word(input int n);
    return (32'(n) << 20) | (32'(n) << 7) | 32'h13;
  endfunction

  int n_ok;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; req_valid = 1'b0;
    kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0; wr_ready = 1'b0;
    exp_addr = '0;

    vecs[0]  = '{3'd0, 5'd2,  5'd1,  5'd9,  13'h0000, 32'h0000A103, 1'b0};
    vecs[1]  = '{3'd2, 5'd3,  5'd1,  5'd2,  13'h0000, 32'h002081B3, 1'b0};
    vecs[2]  = '{3'd3, 5'd4,  5'd3,  5'd1,  13'h0000, 32'h40118233, 1'b0};
    vecs[3]  = '{3'd4, 5'd5,  5'd6,  5'd7,  13'h0000, 32'h007372B3, 1'b0};
    vecs[4]  = '{3'd5, 5'd8,  5'd9,  5'd10, 13'h0000, 32'h00A4E433, 1'b0};
    vecs[5]  = '{3'd7, 5'd0,  5'd1,  5'd2,  13'h0003, 32'h00000000, 1'b1};
    vecs[6]  = '{3'd6, 5'd11, 5'd12, 5'd13, 13'h0000, 32'h00D625B3, 1'b0};
    vecs[7]  = '{3'd1, 5'd1,  5'd2,  5'd31, 13'h1FFF, 32'hFFF10093, 1'b0};
    vecs[8]  = '{3'd1, 5'd1,  5'd0,  5'd0,  13'h1000, 32'h00000000, 1'b1};
    vecs[9]  = '{3'd0, 5'd31, 5'd31, 5'd0,  13'h1800, 32'h800FAF83, 1'b0};
    vecs[10] = '{3'd0, 5'd1,  5'd1,  5'd0,  13'h0800, 32'h00000000, 1'b1};
    vecs[11] = '{3'd7, 5'd7,  5'd3,  5'd4,  13'h1FFC, 32'hFE418EE3, 1'b0};
    vecs[12] = '{3'd1, 5'd1,  5'd0,  5'd0,  13'h07FF, 32'h7FF00093, 1'b0};
    vecs[13] = '{3'd7, 5'd0,  5'd1,  5'd2,  13'h0008, 32'h00208463, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_state", fsm_state, 0);

    // Single ADDI program, one-cycle accept-to-write latency
    rdy_mode = 1;
    @(posedge clk); #1;
    do_start(32'h100);
    check("run_busy", busy, 1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 32'h00500093, 1'b0);
    @(negedge clk);
    check("latency_wr_valid", wr_valid, 1);
    check("first_word", {wr_addr, wr_data}, {32'h100, 32'h00500093});
    wait_done(16'd1, 1'b0);

    // Four-instruction program at address 0
    do_start(32'h0);
    send(3'd0, 5'd2, 5'd1, 5'd0, 13'd0, 1'b0, 32'h0000A103, 1'b0);
    send(3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'h002081B3, 1'b0);
    send(3'd3, 5'd4, 5'd3, 5'd1, 13'd0, 1'b0, 32'h40118233, 1'b0);
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1, 32'h00208463, 1'b0);
    wait_done(16'd4, 1'b0);

    // Table of encodings with random write backpressure
    rdy_mode = 2;
    do_start(32'h2002);
    n_ok = 0;
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
           (i == 13), vecs[i].word, vecs[i].rej);
      if (!vecs[i].rej) n_ok++;
    end
    wait_done(16'(n_ok), 1'b1);
    repeat (3) @(negedge clk);
    check("idle_hold_count", count, 16'(n_ok));
    check("idle_hold_err", err, 1);
    @(posedge clk); #1;

    // Full FIFO under backpressure, then release
    rdy_mode = 0;
    @(posedge clk); #1;
    do_start(32'h40);
    for (int n = 1; n <= 4; n++) send(3'd1, 5'(n), 5'd0, 5'd0, 13'(n), 1'b0, addi_word(n), 1'b0);
    req_valid = 1'b1; kind = 3'd1; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd5; last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_req_ready", req_ready, 0);
      check("full_head", {wr_addr, wr_data}, {32'h40, addi_word(1)});
    end
    rdy_mode = 1;
    @(negedge clk);
    check("full_pop_req_ready", req_ready, 1);
    exp_q.push_back({exp_addr, addi_word(5)});
    exp_addr += 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; last = 1'b0;
    wait_done(16'd5, 1'b0);

    // Rejected requests, ignored start, last on a rejected request
    do_start(32'h300);
    send(3'd7, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 32'h0, 1'b1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 13'h1000, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("rej_err", err, 1);
    check("rej_count", count, 0);
    check("rej_wr_valid", wr_valid, 0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h0099_9000;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ignored_state", fsm_state, 1);
    check("start_ignored_err", err, 1);
    @(posedge clk); #1;
    send(3'd1, 5'd5, 5'd0, 5'd0, 13'd1, 1'b0, 32'h00100293, 1'b0);
    send(3'd0, 5'd1, 5'd1, 5'd0, 13'h0800, 1'b1, 32'h0, 1'b1);
    wait_done(16'd1, 1'b1);

    // Reset with words queued; reset also wins over a simultaneous start
    rdy_mode = 0;
    @(posedge clk); #1;
    do_start(32'h500);
    for (int n = 1; n <= 3; n++) send(3'd1, 5'(n), 5'd0, 5'd0, 13'(n), 1'b0, addi_word(n), 1'b0);
    reset = 1'b1; start = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_state", fsm_state, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 0);
      check("mid_rst_no_valid", wr_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
